// File: rtl/agu_pkg.sv
// Shared parameters and request record for the AGU operand-fetch stage.
package agu_pkg;

    localparam int NLANE = 3;
    localparam int DW    = 65;
    localparam int RW    = 6;

    // All-ones tag means the operand has no source register and reads as zero.
    localparam logic [RW-1:0] REG_NONE = {RW{1'b1}};

    typedef struct packed {
        logic [2:0]    index;
        logic [5:0]    op;
        logic [RW-1:0] rT;
        logic [RW-1:0] basereg;
        logic [RW-1:0] indexreg;
        logic [DW-1:0] offset;
    } opnd_req_t;

endpackage

// File: rtl/agu_bypass_mux.sv
// Writeback bypass selector for one operand tag.
// Priority, highest first: ld2, ld1, ld0, alu2, alu1, alu0.
module agu_bypass_mux
    import agu_pkg::*;
(
    input  logic [RW-1:0]            tag_i,
    input  logic [DW-1:0]            fallback_i,
    input  logic [NLANE-1:0]         alu_wen_i,
    input  logic [NLANE-1:0][RW-1:0] alu_rt_i,
    input  logic [NLANE-1:0][DW-1:0] alu_data_i,
    input  logic [NLANE-1:0]         ld_en_i,
    input  logic [NLANE-1:0][RW-1:0] ld_rt_i,
    input  logic [NLANE-1:0][DW-1:0] ld_data_i,
    output logic                     hit_o,
    output logic [DW-1:0]            data_o
);

    // Later matches overwrite earlier ones, so ports are scanned lowest priority first.
    always_comb begin
        hit_o  = 1'b0;
        data_o = fallback_i;
        if (tag_i != REG_NONE) begin
            for (int i = 0; i < NLANE; i++) begin
                if (alu_wen_i[i] && (alu_rt_i[i] == tag_i)) begin
                    hit_o  = 1'b1;
                    data_o = alu_data_i[i];
                end
            end
            for (int i = 0; i < NLANE; i++) begin
                if (ld_en_i[i] && (ld_rt_i[i] == tag_i)) begin
                    hit_o  = 1'b1;
                    data_o = ld_data_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/agu_opnd_stage.sv
// Operand-fetch stage for the three AGU lanes: S1 (RF read) and S2 (operand hold).
// Writebacks are bypassed over RF data; held operands keep snooping writebacks.
module agu_opnd_stage
    import agu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    output logic                     in_rdy,

    input  logic                     ls0_en,
    input  logic [2:0]               ls0_index,
    input  logic [5:0]               ls0_op,
    input  logic [RW-1:0]            ls0_basereg,
    input  logic [RW-1:0]            ls0_indexreg,
    input  logic [DW-1:0]            ls0_offset,
    input  logic [RW-1:0]            ls0_rT,
    input  logic                     ls1_en,
    input  logic [2:0]               ls1_index,
    input  logic [5:0]               ls1_op,
    input  logic [RW-1:0]            ls1_basereg,
    input  logic [RW-1:0]            ls1_indexreg,
    input  logic [DW-1:0]            ls1_offset,
    input  logic [RW-1:0]            ls1_rT,
    input  logic                     ls2_en,
    input  logic [2:0]               ls2_index,
    input  logic [5:0]               ls2_op,
    input  logic [RW-1:0]            ls2_basereg,
    input  logic [RW-1:0]            ls2_indexreg,
    input  logic [DW-1:0]            ls2_offset,
    input  logic [RW-1:0]            ls2_rT,

    output logic [2*NLANE*RW-1:0]    rf_raddr,
    input  logic [2*NLANE*DW-1:0]    rf_rdata,

    input  logic                     alu0_wen,
    input  logic [RW-1:0]            alu0_rT,
    input  logic [DW-1:0]            alu0_data,
    input  logic                     alu1_wen,
    input  logic [RW-1:0]            alu1_rT,
    input  logic [DW-1:0]            alu1_data,
    input  logic                     alu2_wen,
    input  logic [RW-1:0]            alu2_rT,
    input  logic [DW-1:0]            alu2_data,
    input  logic                     ld0_en_out,
    input  logic [RW-1:0]            ld0_rT,
    input  logic [DW-1:0]            ld0_data_out,
    input  logic                     ld1_en_out,
    input  logic [RW-1:0]            ld1_rT,
    input  logic [DW-1:0]            ld1_data_out,
    input  logic                     ld2_en_out,
    input  logic [RW-1:0]            ld2_rT,
    input  logic [DW-1:0]            ld2_data_out,

    output logic                     agu0_en,
    output logic [2:0]               agu0_index,
    output logic [5:0]               agu0_op,
    output logic [RW-1:0]            agu0_rT,
    output logic [DW-1:0]            agu0_base,
    output logic [DW-1:0]            agu0_idx,
    output logic [DW-1:0]            agu0_offset,
    output logic                     agu1_en,
    output logic [2:0]               agu1_index,
    output logic [5:0]               agu1_op,
    output logic [RW-1:0]            agu1_rT,
    output logic [DW-1:0]            agu1_base,
    output logic [DW-1:0]            agu1_idx,
    output logic [DW-1:0]            agu1_offset,
    output logic                     agu2_en,
    output logic [2:0]               agu2_index,
    output logic [5:0]               agu2_op,
    output logic [RW-1:0]            agu2_rT,
    output logic [DW-1:0]            agu2_base,
    output logic [DW-1:0]            agu2_idx,
    output logic [DW-1:0]            agu2_offset
);

    logic [NLANE-1:0]          ls_en;
    opnd_req_t                 ls_req [NLANE];
    logic [NLANE-1:0]          alu_wen;
    logic [NLANE-1:0][RW-1:0]  alu_rt;
    logic [NLANE-1:0][DW-1:0]  alu_data;
    logic [NLANE-1:0]          ld_en;
    logic [NLANE-1:0][RW-1:0]  ld_rt;
    logic [NLANE-1:0][DW-1:0]  ld_data;

    logic [NLANE-1:0]          agu_en_w;
    logic [2:0]                agu_index_w [NLANE];
    logic [5:0]                agu_op_w    [NLANE];
    logic [RW-1:0]             agu_rt_w    [NLANE];
    logic [DW-1:0]             agu_off_w   [NLANE];
    logic [DW-1:0]             agu_opnd_w  [NLANE][2];

    assign in_rdy = ~stall;

    assign ls_en     = {ls2_en, ls1_en, ls0_en};
    assign ls_req[0] = '{index: ls0_index, op: ls0_op, rT: ls0_rT, basereg: ls0_basereg,
                         indexreg: ls0_indexreg, offset: ls0_offset};
    assign ls_req[1] = '{index: ls1_index, op: ls1_op, rT: ls1_rT, basereg: ls1_basereg,
                         indexreg: ls1_indexreg, offset: ls1_offset};
    assign ls_req[2] = '{index: ls2_index, op: ls2_op, rT: ls2_rT, basereg: ls2_basereg,
                         indexreg: ls2_indexreg, offset: ls2_offset};

    assign alu_wen  = {alu2_wen, alu1_wen, alu0_wen};
    assign alu_rt   = {alu2_rT, alu1_rT, alu0_rT};
    assign alu_data = {alu2_data, alu1_data, alu0_data};
    assign ld_en    = {ld2_en_out, ld1_en_out, ld0_en_out};
    assign ld_rt    = {ld2_rT, ld1_rT, ld0_rT};
    assign ld_data  = {ld2_data_out, ld1_data_out, ld0_data_out};

    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        logic               s1_vld_q;
        logic               s1_fresh_q;
        logic               s2_vld_q;
        opnd_req_t          s1_req_q;
        opnd_req_t          s2_req_q;
        logic [1:0][RW-1:0] in_tag;
        logic [1:0][RW-1:0] s1_tag;
        logic [1:0][RW-1:0] s2_tag;

        // Operand 0 is the base register, operand 1 the index register.
        assign in_tag = {ls_req[l].indexreg, ls_req[l].basereg};
        assign s1_tag = {s1_req_q.indexreg, s1_req_q.basereg};
        assign s2_tag = {s2_req_q.indexreg, s2_req_q.basereg};
        assign rf_raddr[2*l*RW +: 2*RW] = in_tag;

        // Valids and passthrough fields advance together; stall freezes both stages.
        // s1_fresh_q marks the one cycle in which rf_rdata belongs to S1.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_vld_q   <= 1'b0;
                s1_fresh_q <= 1'b0;
                s2_vld_q   <= 1'b0;
                s1_req_q   <= '0;
                s2_req_q   <= '0;
            end else if (!stall) begin
                s1_vld_q   <= ls_en[l];
                s1_fresh_q <= 1'b1;
                s1_req_q   <= ls_req[l];
                s2_vld_q   <= s1_vld_q;
                s2_req_q   <= s1_req_q;
            end else begin
                s1_fresh_q <= 1'b0;
            end
        end

        for (genvar j = 0; j < 2; j++) begin : g_opnd
            logic          pend_vld_q;
            logic [DW-1:0] pend_q;
            logic [DW-1:0] s2_opnd_q;
            logic [DW-1:0] rf_data;
            logic [DW-1:0] s1_data;
            logic [DW-1:0] pend_fb;
            logic [DW-1:0] s2_fb;
            logic          pend_hit;
            logic [DW-1:0] pend_mux;
            logic          s2_hit;
            logic [DW-1:0] s2_mux;

            assign rf_data = rf_rdata[(2*l+j)*DW +: DW];
            // Pending data is newer than the RF read, which predates the capture-cycle writeback.
            assign s1_data = pend_vld_q ? pend_q : rf_data;
            assign pend_fb = s1_fresh_q ? s1_data : pend_q;
            assign s2_fb   = stall ? s2_opnd_q : s1_data;

            agu_bypass_mux u_pend_byp (
                .tag_i      (stall ? s1_tag[j] : in_tag[j]),
                .fallback_i (pend_fb),
                .alu_wen_i  (alu_wen),
                .alu_rt_i   (alu_rt),
                .alu_data_i (alu_data),
                .ld_en_i    (ld_en),
                .ld_rt_i    (ld_rt),
                .ld_data_i  (ld_data),
                .hit_o      (pend_hit),
                .data_o     (pend_mux)
            );

            agu_bypass_mux u_s2_byp (
                .tag_i      (stall ? s2_tag[j] : s1_tag[j]),
                .fallback_i (s2_fb),
                .alu_wen_i  (alu_wen),
                .alu_rt_i   (alu_rt),
                .alu_data_i (alu_data),
                .ld_en_i    (ld_en),
                .ld_rt_i    (ld_rt),
                .ld_data_i  (ld_data),
                .hit_o      (s2_hit),
                .data_o     (s2_mux)
            );

            // S1 pending: record capture-cycle writebacks, then absorb RF data and snoop while held.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pend_vld_q <= 1'b0;
                    pend_q     <= '0;
                end else if (!stall) begin
                    pend_vld_q <= pend_hit;
                    pend_q     <= pend_mux;
                end else begin
                    pend_vld_q <= pend_vld_q | s1_fresh_q;
                    pend_q     <= pend_mux;
                end
            end

            // S2 operand: resolve on capture, snoop in place while held and valid.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s2_opnd_q <= '0;
                end else if (!stall) begin
                    s2_opnd_q <= (s1_tag[j] == REG_NONE) ? '0 : s2_mux;
                end else if (s2_vld_q && s2_hit) begin
                    s2_opnd_q <= s2_mux;
                end
            end

            assign agu_opnd_w[l][j] = s2_opnd_q;
        end

        assign agu_en_w[l]    = s2_vld_q;
        assign agu_index_w[l] = s2_req_q.index;
        assign agu_op_w[l]    = s2_req_q.op;
        assign agu_rt_w[l]    = s2_req_q.rT;
        assign agu_off_w[l]   = s2_req_q.offset;
    end

    assign agu0_en     = agu_en_w[0];
    assign agu0_index  = agu_index_w[0];
    assign agu0_op     = agu_op_w[0];
    assign agu0_rT     = agu_rt_w[0];
    assign agu0_base   = agu_opnd_w[0][0];
    assign agu0_idx    = agu_opnd_w[0][1];
    assign agu0_offset = agu_off_w[0];

    assign agu1_en     = agu_en_w[1];
    assign agu1_index  = agu_index_w[1];
    assign agu1_op     = agu_op_w[1];
    assign agu1_rT     = agu_rt_w[1];
    assign agu1_base   = agu_opnd_w[1][0];
    assign agu1_idx    = agu_opnd_w[1][1];
    assign agu1_offset = agu_off_w[1];

    assign agu2_en     = agu_en_w[2];
    assign agu2_index  = agu_index_w[2];
    assign agu2_op     = agu_op_w[2];
    assign agu2_rT     = agu_rt_w[2];
    assign agu2_base   = agu_opnd_w[2][0];
    assign agu2_idx    = agu_opnd_w[2][1];
    assign agu2_offset = agu_off_w[2];

endmodule

// File: tb/tb_agu_opnd_stage.sv
// Bench for agu_opnd_stage. The reference treats the register file as an architectural
// array: every valid output must show the current value of its tag, with the issue record
// taken from two accepted (non-stalled) cycles earlier.
module tb_agu_opnd_stage;
    import agu_pkg::*;

    typedef struct packed {
        logic          en;
        logic [2:0]    index;
        logic [5:0]    op;
        logic [RW-1:0] rt;
        logic [RW-1:0] base;
        logic [RW-1:0] ireg;
        logic [DW-1:0] off;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic in_rdy;

    logic [NLANE-1:0] ls_en;
    logic [2:0]       ls_index [NLANE];
    logic [5:0]       ls_op    [NLANE];
    logic [RW-1:0]    ls_base  [NLANE];
    logic [RW-1:0]    ls_ireg  [NLANE];
    logic [RW-1:0]    ls_rt    [NLANE];
    logic [DW-1:0]    ls_off   [NLANE];

    logic [NLANE-1:0] alu_wen;
    logic [RW-1:0]    alu_rt   [NLANE];
    logic [DW-1:0]    alu_data [NLANE];
    logic [NLANE-1:0] ld_en;
    logic [RW-1:0]    ld_rt    [NLANE];
    logic [DW-1:0]    ld_data  [NLANE];

    logic [2*NLANE*RW-1:0] rf_raddr;
    logic [2*NLANE*DW-1:0] rf_rdata;

    logic [NLANE-1:0] agu_en;
    logic [2:0]       agu_index [NLANE];
    logic [5:0]       agu_op    [NLANE];
    logic [RW-1:0]    agu_rt    [NLANE];
    logic [DW-1:0]    agu_base  [NLANE];
    logic [DW-1:0]    agu_idx   [NLANE];
    logic [DW-1:0]    agu_off   [NLANE];

    logic [DW-1:0] regs [64];
    rec_t          h1 [NLANE];
    rec_t          h2 [NLANE];
    int            hcnt;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    agu_opnd_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .in_rdy(in_rdy),
        .ls0_en(ls_en[0]), .ls0_index(ls_index[0]), .ls0_op(ls_op[0]), .ls0_basereg(ls_base[0]),
        .ls0_indexreg(ls_ireg[0]), .ls0_offset(ls_off[0]), .ls0_rT(ls_rt[0]),
        .ls1_en(ls_en[1]), .ls1_index(ls_index[1]), .ls1_op(ls_op[1]), .ls1_basereg(ls_base[1]),
        .ls1_indexreg(ls_ireg[1]), .ls1_offset(ls_off[1]), .ls1_rT(ls_rt[1]),
        .ls2_en(ls_en[2]), .ls2_index(ls_index[2]), .ls2_op(ls_op[2]), .ls2_basereg(ls_base[2]),
        .ls2_indexreg(ls_ireg[2]), .ls2_offset(ls_off[2]), .ls2_rT(ls_rt[2]),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .alu0_wen(alu_wen[0]), .alu0_rT(alu_rt[0]), .alu0_data(alu_data[0]),
        .alu1_wen(alu_wen[1]), .alu1_rT(alu_rt[1]), .alu1_data(alu_data[1]),
        .alu2_wen(alu_wen[2]), .alu2_rT(alu_rt[2]), .alu2_data(alu_data[2]),
        .ld0_en_out(ld_en[0]), .ld0_rT(ld_rt[0]), .ld0_data_out(ld_data[0]),
        .ld1_en_out(ld_en[1]), .ld1_rT(ld_rt[1]), .ld1_data_out(ld_data[1]),
        .ld2_en_out(ld_en[2]), .ld2_rT(ld_rt[2]), .ld2_data_out(ld_data[2]),
        .agu0_en(agu_en[0]), .agu0_index(agu_index[0]), .agu0_op(agu_op[0]), .agu0_rT(agu_rt[0]),
        .agu0_base(agu_base[0]), .agu0_idx(agu_idx[0]), .agu0_offset(agu_off[0]),
        .agu1_en(agu_en[1]), .agu1_index(agu_index[1]), .agu1_op(agu_op[1]), .agu1_rT(agu_rt[1]),
        .agu1_base(agu_base[1]), .agu1_idx(agu_idx[1]), .agu1_offset(agu_off[1]),
        .agu2_en(agu_en[2]), .agu2_index(agu_index[2]), .agu2_op(agu_op[2]), .agu2_rT(agu_rt[2]),
        .agu2_base(agu_base[2]), .agu2_idx(agu_idx[2]), .agu2_offset(agu_off[2])
    );

    function automatic logic [DW-1:0] rand_dw();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    function automatic logic [RW-1:0] rand_tag();
        if ($urandom_range(0, 7) == 0) return REG_NONE;
        return RW'($urandom_range(0, 7));
    endfunction

    function automatic logic [DW-1:0] rval(input logic [RW-1:0] t);
        return (t == REG_NONE) ? '0 : regs[t];
    endfunction

    task automatic idle();
        stall   = 1'b0;
        ls_en   = '0;
        alu_wen = '0;
        ld_en   = '0;
        for (int l = 0; l < NLANE; l++) begin
            ls_index[l] = '0; ls_op[l] = '0; ls_base[l] = '0;
            ls_ireg[l]  = '0; ls_rt[l] = '0; ls_off[l]  = '0;
            alu_rt[l] = '0; alu_data[l] = '0; ld_rt[l] = '0; ld_data[l] = '0;
        end
    endtask

    task automatic issue(input int l, input logic [RW-1:0] b, input logic [RW-1:0] x,
                         input logic [DW-1:0] off, input logic [2:0] ix, input logic [5:0] op,
                         input logic [RW-1:0] rt);
        ls_en[l] = 1'b1; ls_base[l] = b; ls_ireg[l] = x; ls_off[l] = off;
        ls_index[l] = ix; ls_op[l] = op; ls_rt[l] = rt;
    endtask

    // One clock: the RF answers the tags presented this cycle on the next one, writebacks
    // land in the architectural array, and the issue history advances when not stalled.
    task automatic cycle();
        rec_t                  cur [NLANE];
        logic [2*NLANE*DW-1:0] rd;
        @(posedge clk);
        for (int l = 0; l < NLANE; l++) begin
            cur[l] = '{en: ls_en[l], index: ls_index[l], op: ls_op[l], rt: ls_rt[l],
                       base: ls_base[l], ireg: ls_ireg[l], off: ls_off[l]};
            rd[2*l*DW +: DW]     = regs[ls_base[l]];
            rd[(2*l+1)*DW +: DW] = regs[ls_ireg[l]];
        end
        if (!rst) begin
            hcnt = 0;
        end else if (!stall) begin
            for (int l = 0; l < NLANE; l++) begin
                h2[l] = h1[l];
                h1[l] = cur[l];
            end
            if (hcnt < 2) hcnt++;
        end
        for (int i = 0; i < NLANE; i++) if (alu_wen[i]) regs[alu_rt[i]] = alu_data[i];
        for (int i = 0; i < NLANE; i++) if (ld_en[i]) regs[ld_rt[i]] = ld_data[i];
        #1;
        rf_rdata = rd;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        for (int l = 0; l < NLANE; l++) issue(l, RW'(l), RW'(l + 1), 65'h40, 3'd1, 6'd2, 6'd3);
        cycle(); cycle();
        checks++; if (agu_en[0] !== 1'b1) begin errors++; $display("FAIL reset_pre_en got %b exp 1", agu_en[0]); end
        #3;
        rst = 1'b0;
        #1;
        for (int l = 0; l < NLANE; l++) begin
            checks++; if (agu_en[l] !== 1'b0) begin errors++; $display("FAIL reset_en lane%0d got %b exp 0", l, agu_en[l]); end
            checks++; if (agu_base[l] !== '0) begin errors++; $display("FAIL reset_base lane%0d got %h exp 0", l, agu_base[l]); end
        end
        cycle();
        rst = 1'b1;
        idle();
        issue(0, 6'd1, 6'd2, 65'h8, 3'd2, 6'd5, 6'd6);
        cycle();
        idle();
        checks++; if (agu_en[0] !== 1'b0) begin errors++; $display("FAIL reset_t1_en got %b exp 0", agu_en[0]); end
        cycle();
        checks++; if (agu_en[0] !== 1'b1) begin errors++; $display("FAIL reset_t2_en got %b exp 1", agu_en[0]); end
        checks++; if (agu_base[0] !== regs[1]) begin errors++; $display("FAIL reset_t2_base got %h exp %h", agu_base[0], regs[1]); end
        cycle(); cycle();
    endtask

    task automatic test_plain_read();
        idle();
        regs[5] = 65'h1000;
        regs[7] = 65'h20;
        issue(0, 6'd5, 6'd7, 65'h10, 3'd3, 6'h12, 6'd9);
        #1;
        checks++; if (rf_raddr[11:0] !== {6'd7, 6'd5}) begin errors++; $display("FAIL plain_raddr got %h exp %h", rf_raddr[11:0], {6'd7, 6'd5}); end
        cycle();
        idle();
        cycle();
        checks++; if (agu_en[0] !== 1'b1) begin errors++; $display("FAIL plain_en got %b exp 1", agu_en[0]); end
        checks++; if (agu_base[0] !== 65'h1000) begin errors++; $display("FAIL plain_base got %h exp 1000", agu_base[0]); end
        checks++; if (agu_idx[0] !== 65'h20) begin errors++; $display("FAIL plain_idx got %h exp 20", agu_idx[0]); end
        checks++; if (agu_off[0] !== 65'h10) begin errors++; $display("FAIL plain_off got %h exp 10", agu_off[0]); end
        checks++; if ({agu_index[0], agu_op[0], agu_rt[0]} !== {3'd3, 6'h12, 6'd9}) begin
            errors++; $display("FAIL plain_pass got %h/%h/%h exp 3/12/9", agu_index[0], agu_op[0], agu_rt[0]);
        end
        cycle(); cycle();
    endtask

    task automatic test_same_cycle_bypass();
        idle();
        regs[5] = 65'h1000;
        regs[7] = 65'h20;
        issue(0, 6'd5, 6'd7, 65'h10, 3'd0, 6'd1, 6'd2);
        cycle();
        idle();
        alu_wen[1] = 1'b1; alu_rt[1] = 6'd5; alu_data[1] = 65'hABCD;
        ld_en[0]   = 1'b1; ld_rt[0]  = 6'd7; ld_data[0]  = 65'h777;
        alu_wen[0] = 1'b1; alu_rt[0] = 6'd7; alu_data[0] = 65'h333;
        cycle();
        idle();
        checks++; if (agu_base[0] !== 65'hABCD) begin errors++; $display("FAIL scbyp_base got %h exp abcd", agu_base[0]); end
        checks++; if (agu_idx[0] !== 65'h777) begin errors++; $display("FAIL scbyp_prio got %h exp 777", agu_idx[0]); end
        cycle(); cycle();
    endtask

    task automatic test_early_bypass();
        idle();
        regs[5] = 65'h11;
        issue(0, 6'd5, REG_NONE, 65'h0, 3'd0, 6'd1, 6'd2);
        ld_en[2]   = 1'b1; ld_rt[2]  = 6'd5; ld_data[2]  = 65'h55;
        alu_wen[2] = 1'b1; alu_rt[2] = 6'd5; alu_data[2] = 65'h66;
        cycle();
        idle();
        cycle();
        checks++; if (agu_base[0] !== 65'h55) begin errors++; $display("FAIL early_base got %h exp 55", agu_base[0]); end
        checks++; if (agu_idx[0] !== '0) begin errors++; $display("FAIL early_none_idx got %h exp 0", agu_idx[0]); end
        cycle(); cycle();
    endtask

    task automatic test_stall_snoop();
        idle();
        regs[9]  = 65'h9;
        regs[12] = 65'h12;
        issue(0, 6'd9, REG_NONE, 65'h1, 3'd1, 6'd1, 6'd1);
        cycle();
        idle();
        issue(0, 6'd12, 6'd9, 65'h2, 3'd2, 6'd2, 6'd2);
        cycle();
        idle();
        stall = 1'b1;
        alu_wen[0] = 1'b1; alu_rt[0] = 6'd12; alu_data[0] = 65'hC12;
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy1 got %b exp 0", in_rdy); end
        cycle();
        checks++; if (agu_en[0] !== 1'b1) begin errors++; $display("FAIL stall_en1 got %b exp 1", agu_en[0]); end
        checks++; if (agu_base[0] !== 65'h9) begin errors++; $display("FAIL stall_base1 got %h exp 9", agu_base[0]); end
        alu_wen[0] = 1'b0;
        alu_wen[2] = 1'b1; alu_rt[2] = 6'd9; alu_data[2] = 65'h99;
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy2 got %b exp 0", in_rdy); end
        cycle();
        checks++; if (agu_base[0] !== 65'h99) begin errors++; $display("FAIL stall_snoop got %h exp 99", agu_base[0]); end
        alu_wen[2] = 1'b0;
        cycle();
        checks++; if ({agu_en[0], in_rdy} !== 2'b10) begin errors++; $display("FAIL stall_hold3 got en=%b rdy=%b exp en=1 rdy=0", agu_en[0], in_rdy); end
        checks++; if (agu_off[0] !== 65'h1) begin errors++; $display("FAIL stall_off got %h exp 1", agu_off[0]); end
        stall = 1'b0;
        #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL stall_rdy_rel got %b exp 1", in_rdy); end
        cycle();
        checks++; if (agu_base[0] !== 65'hC12) begin errors++; $display("FAIL s1pend_base got %h exp c12", agu_base[0]); end
        checks++; if (agu_idx[0] !== 65'h99) begin errors++; $display("FAIL s1pend_idx got %h exp 99", agu_idx[0]); end
        cycle(); cycle();
    endtask

    task automatic test_none_tag_parallel();
        idle();
        regs[63] = 65'hBAD;
        regs[1] = 65'h101; regs[2] = 65'h202; regs[3] = 65'h303; regs[4] = 65'h404;
        issue(0, REG_NONE, 6'd4, 65'h0, 3'd0, 6'd0, 6'd0);
        issue(1, 6'd1, 6'd2, 65'h0, 3'd1, 6'd0, 6'd0);
        issue(2, 6'd3, REG_NONE, 65'h0, 3'd2, 6'd0, 6'd0);
        alu_wen[0] = 1'b1; alu_rt[0] = REG_NONE; alu_data[0] = 65'hDEAD;
        cycle();
        ls_en = '0;
        cycle();
        idle();
        checks++; if (agu_en !== 3'b111) begin errors++; $display("FAIL none_en got %b exp 111", agu_en); end
        checks++; if (agu_base[0] !== '0) begin errors++; $display("FAIL none_base0 got %h exp 0", agu_base[0]); end
        checks++; if (agu_idx[0] !== 65'h404) begin errors++; $display("FAIL none_idx0 got %h exp 404", agu_idx[0]); end
        checks++; if ({agu_base[1], agu_idx[1]} !== {65'h101, 65'h202}) begin errors++; $display("FAIL par_lane1 got %h/%h exp 101/202", agu_base[1], agu_idx[1]); end
        checks++; if ({agu_base[2], agu_idx[2]} !== {65'h303, 65'h0}) begin errors++; $display("FAIL par_lane2 got %h/%h exp 303/0", agu_base[2], agu_idx[2]); end
        checks++; if (agu_index[2] !== 3'd2) begin errors++; $display("FAIL par_index2 got %0d exp 2", agu_index[2]); end
        cycle(); cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            idle();
            stall = ($urandom_range(0, 3) == 0);
            for (int l = 0; l < NLANE; l++) begin
                ls_en[l] = !stall && ($urandom_range(0, 1) == 1);
                ls_base[l] = rand_tag(); ls_ireg[l] = rand_tag(); ls_rt[l] = RW'($urandom_range(0, 63));
                ls_index[l] = 3'($urandom_range(0, 7)); ls_op[l] = 6'($urandom_range(0, 63));
                ls_off[l] = rand_dw();
                alu_wen[l] = ($urandom_range(0, 1) == 1); alu_rt[l] = rand_tag(); alu_data[l] = rand_dw();
                ld_en[l]   = ($urandom_range(0, 2) == 0); ld_rt[l]  = rand_tag(); ld_data[l]  = rand_dw();
            end
            #1;
            checks++; if (in_rdy !== !stall) begin errors++; $display("FAIL rnd_rdy cyc%0d got %b exp %b", c, in_rdy, !stall); end
            cycle();
            for (int l = 0; l < NLANE; l++) begin
                logic exp_en;
                exp_en = (hcnt >= 2) && h2[l].en;
                checks++;
                if (agu_en[l] !== exp_en) begin
                    errors++; $display("FAIL rnd_en cyc%0d lane%0d got %b exp %b", c, l, agu_en[l], exp_en);
                end
                if (exp_en) begin
                    checks++;
                    if (agu_base[l] !== rval(h2[l].base)) begin
                        errors++; $display("FAIL rnd_base cyc%0d lane%0d got %h exp %h", c, l, agu_base[l], rval(h2[l].base));
                    end
                    checks++;
                    if (agu_idx[l] !== rval(h2[l].ireg)) begin
                        errors++; $display("FAIL rnd_idx cyc%0d lane%0d got %h exp %h", c, l, agu_idx[l], rval(h2[l].ireg));
                    end
                    checks++;
                    if ({agu_index[l], agu_op[l], agu_rt[l], agu_off[l]} !== {h2[l].index, h2[l].op, h2[l].rt, h2[l].off}) begin
                        errors++; $display("FAIL rnd_pass cyc%0d lane%0d got %h/%h/%h/%h exp %h/%h/%h/%h", c, l,
                                           agu_index[l], agu_op[l], agu_rt[l], agu_off[l],
                                           h2[l].index, h2[l].op, h2[l].rt, h2[l].off);
                    end
                end
            end
        end
        idle();
        cycle(); cycle();
    endtask

    initial begin
        rf_rdata = '0;
        hcnt = 0;
        for (int i = 0; i < 64; i++) regs[i] = 65'(i * 257 + 3);
        for (int l = 0; l < NLANE; l++) begin
            h1[l] = '0;
            h2[l] = '0;
        end
        test_reset();
        test_plain_read();
        test_same_cycle_bypass();
        test_early_bypass();
        test_stall_snoop();
        test_none_tag_parallel();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
